// File: rtl/sub_mod_pkg.sv
// Base-field constants and subtractor pipeline geometry.
// zprize_param holds the field; sub_mod_pkg holds the stage split.
package zprize_param;
  localparam int W = 378;
  localparam int LIMB_W = 27;
  localparam int NLIMB = W / LIMB_W;
  localparam logic [W-1:0] P = W'(384'h01ae3a4617c510eac63b05c06ca1493b1a22d9f300f5138f1ef3622fba094800170b5d44300000008508c00000000001);
  typedef logic [NLIMB-1:0][LIMB_W-1:0] limb_arr_t;
endpackage

package sub_mod_pkg;
  import zprize_param::*;
  localparam int LIMBS_PER_STG = 2;
  localparam int GW = LIMBS_PER_STG * LIMB_W;
  localparam int NSTG = (NLIMB + LIMBS_PER_STG - 1) / LIMBS_PER_STG;
  localparam int WP = NSTG * GW;
  localparam int LAT = NSTG + 3;
endpackage

// File: rtl/sub_mod_if.sv
// Operand/result bundle of the modular subtractor.
// range_err only exists when SUB_MOD_RANGE_CHK_EN is defined.
interface sub_mod_if #(parameter int TAG_W = 1) ();
  logic [zprize_param::W-1:0] in0;
  logic [zprize_param::W-1:0] in1;
  logic valid;
  logic [TAG_W-1:0] tag;
  logic valid_out;
  logic [TAG_W-1:0] tag_out;
  logic borrow_out;
  logic idle;
  logic [zprize_param::W-1:0] out;
`ifdef SUB_MOD_RANGE_CHK_EN
  logic range_err;

  modport master (
    output in0, in1, valid, tag,
    input valid_out, tag_out, borrow_out,
    input idle, out, range_err
  );
  modport slave (
    input in0, in1, valid, tag,
    output valid_out, tag_out, borrow_out,
    output idle, out, range_err
  );
`else
  modport master (
    output in0, in1, valid, tag,
    input valid_out, tag_out, borrow_out,
    input idle, out
  );
  modport slave (
    input in0, in1, valid, tag,
    output valid_out, tag_out, borrow_out,
    output idle, out
  );
`endif
endinterface

// File: rtl/sub_mod_limb_stg.sv
// One limb group of a skewed carry chain, registered.
// SUB=1 computes x + ~y + cin (cin=1 at the bottom gives x - y).
module sub_mod_limb_stg #(
  parameter int GW = 54,
  parameter bit SUB = 1'b0
) (
  input  logic          clk,
  input  logic [GW-1:0] x,
  input  logic [GW-1:0] y,
  input  logic          cin,
  output logic [GW-1:0] s,
  output logic          cout
);
  logic [GW-1:0] yy;
  logic [GW:0] sum;

  // group sum with the chain carry folded in
  always_comb begin
    yy = SUB ? ~y : y;
    sum = {1'b0, x} + {1'b0, yy} + {{GW{1'b0}}, cin};
  end

  // stage register, no reset on data
  always_ff @(posedge clk) begin
    s <= sum[GW-1:0];
    cout <= sum[GW];
  end
endmodule

// File: rtl/sub_mod.sv
// Pipelined (in0 - in1) mod P, latency NSTG+3, one op per clock.
// Optional SUB_MOD_RANGE_CHK_EN adds range_err (in0>=P or in1>=P).
module sub_mod
  import zprize_param::*;
  import sub_mod_pkg::*;
#(
  parameter int TAG_W = 1
) (
  input logic clk,
  input logic rst,
  sub_mod_if.slave bus
);
  localparam logic [WP-1:0] PX = WP'(P);

  logic [W-1:0] a_q, b_q;
  logic [WP-1:0] a_x, b_x;
  logic [WP-1:0] d_fin, e_fin;
  logic cy_d [NSTG+1];
  logic cy_e [NSTG+1];
  logic [NLIMB-1:0] sel_q;
  logic bd_q;
  limb_arr_t d_l, e_l, out_q;
  logic [LAT-1:0] vld_sr;
  logic [TAG_W-1:0] tag_sr [LAT];

  // S0: capture operands
  always_ff @(posedge clk) begin
    a_q <= bus.in0;
    b_q <= bus.in1;
  end

  assign a_x = WP'(a_q);
  assign b_x = WP'(b_q);
  assign cy_d[0] = 1'b1;
  assign cy_e[0] = 1'b0;

`ifdef SUB_MOD_RANGE_CHK_EN
  logic ge_a [NSTG+1];
  logic ge_b [NSTG+1];
  logic rng_q, rerr_q;

  assign ge_a[0] = 1'b1;
  assign ge_b[0] = 1'b1;
`endif

  for (genvar g = 0; g < NSTG; g++) begin : g_grp
    logic [GW-1:0] a_in, b_in, d_s, e_s;
    logic [GW-1:0] d_dl [NSTG-g];

    if (g == 0) begin : g_a0
      assign a_in = a_x[GW-1:0];
      assign b_in = b_x[GW-1:0];
    end else begin : g_adl
      logic [GW-1:0] a_dl [g];
      logic [GW-1:0] b_dl [g];

      // upper groups wait for the borrow below them
      always_ff @(posedge clk) begin
        a_dl[0] <= a_x[g*GW +: GW];
        b_dl[0] <= b_x[g*GW +: GW];
        for (int j = 1; j < g; j++) begin
          a_dl[j] <= a_dl[j-1];
          b_dl[j] <= b_dl[j-1];
        end
      end

      assign a_in = a_dl[g-1];
      assign b_in = b_dl[g-1];
    end

    sub_mod_limb_stg #(.GW(GW), .SUB(1'b1)) u_d (
      .clk(clk),
      .x(a_in),
      .y(b_in),
      .cin(cy_d[g]),
      .s(d_s),
      .cout(cy_d[g+1])
    );

    sub_mod_limb_stg #(.GW(GW), .SUB(1'b0)) u_e (
      .clk(clk),
      .x(d_s),
      .y(PX[g*GW +: GW]),
      .cin(cy_e[g]),
      .s(e_s),
      .cout(cy_e[g+1])
    );

    // finished d groups ride along to the select stage
    always_ff @(posedge clk) begin
      d_dl[0] <= d_s;
      for (int j = 1; j < NSTG - g; j++) begin
        d_dl[j] <= d_dl[j-1];
      end
    end

    assign d_fin[g*GW +: GW] = d_dl[NSTG-g-1];

    if (g == NSTG - 1) begin : g_e0
      assign e_fin[g*GW +: GW] = e_s;
    end else begin : g_edl
      logic [GW-1:0] e_dl [NSTG-1-g];

      // finished e groups ride along to the select stage
      always_ff @(posedge clk) begin
        e_dl[0] <= e_s;
        for (int j = 1; j < NSTG - 1 - g; j++) begin
          e_dl[j] <= e_dl[j-1];
        end
      end

      assign e_fin[g*GW +: GW] = e_dl[NSTG-2-g];
    end

`ifdef SUB_MOD_RANGE_CHK_EN
    logic ga_q, gb_q;

    // a>=P / b>=P, lsb group first, equal passes the lower result up
    always_ff @(posedge clk) begin
      ga_q <= (a_in > PX[g*GW +: GW]) |
              ((a_in == PX[g*GW +: GW]) & ge_a[g]);
      gb_q <= (b_in > PX[g*GW +: GW]) |
              ((b_in == PX[g*GW +: GW]) & ge_b[g]);
    end

    assign ge_a[g+1] = ga_q;
    assign ge_b[g+1] = gb_q;
`endif
  end

  assign d_l = d_fin[W-1:0];
  assign e_l = e_fin[W-1:0];

  // final borrow, one select copy per limb
  always_ff @(posedge clk) begin
    sel_q <= {NLIMB{~cy_d[NSTG]}};
  end

  // select d or d+P per limb
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      bd_q <= 1'b0;
    end else begin
      bd_q <= sel_q[0];
      for (int i = 0; i < NLIMB; i++) begin
        out_q[i] <= sel_q[i] ? e_l[i] : d_l[i];
      end
    end
  end

  // valid and tag travel beside the data
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_sr[i] <= '0;
      end
    end else begin
      vld_sr <= {vld_sr[LAT-2:0], bus.valid};
      tag_sr[0] <= bus.tag;
      for (int i = 1; i < LAT; i++) begin
        tag_sr[i] <= tag_sr[i-1];
      end
    end
  end

`ifdef SUB_MOD_RANGE_CHK_EN
  // range flag joins the select and output stages
  always_ff @(posedge clk) begin
    rng_q <= ge_a[NSTG] | ge_b[NSTG];
    if (rst) begin
      rerr_q <= 1'b0;
    end else begin
      rerr_q <= rng_q;
    end
  end

  assign bus.range_err = rerr_q;
`endif

  assign bus.valid_out = vld_sr[LAT-1];
  assign bus.tag_out = tag_sr[LAT-1];
  assign bus.borrow_out = bd_q;
  assign bus.out = out_q;
  assign bus.idle = ~bus.valid & ~|vld_sr;
endmodule

// File: tb/tb_sub_mod.sv
// Scoreboard bench for sub_mod: random and corner operands,
// bubbles, idle tracking, mid-stream reset, optional range_err.
module tb_sub_mod;
  import zprize_param::*;

  localparam int TAG_W = 1;
  localparam int LATENCY = 10;

  typedef struct {
    logic [W-1:0] out;
    logic bor;
    logic [TAG_W-1:0] tag;
    logic rerr;
    logic dchk;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;
  exp_t sbq[$];
  exp_t me;

  sub_mod_if #(.TAG_W(TAG_W)) bus ();

  sub_mod #(.TAG_W(TAG_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [W-1:0] act,
                              logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, act, exp, cyc);
  endfunction

  // reference: plain modular arithmetic on whole numbers
  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b,
                                 logic [TAG_W-1:0] t, int c);
    exp_t e;
    e.bor = (a < b);
    if (a >= b) e.out = a - b;
    else e.out = P - (b - a);
    e.tag = t;
    e.rerr = (a >= P) || (b >= P);
    e.dchk = !e.rerr;
    e.cyc = c;
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_fe();
    logic [W-1:0] x;
    x = '0;
    for (int i = 0; i < 12; i++) x = {x[W-33:0], 32'($urandom)};
    while (x >= P) x = x - P;
    return x;
  endfunction

  task automatic pick(output logic [W-1:0] a, output logic [W-1:0] b);
    case ($urandom_range(0, 7))
      0: begin a = rnd_fe(); b = a; end
      1: begin a = '0; b = rnd_fe(); end
      2: begin a = P - W'(1); b = rnd_fe(); end
      3: begin a = rnd_fe(); b = P - W'(1); end
      default: begin a = rnd_fe(); b = rnd_fe(); end
    endcase
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic [TAG_W-1:0] t);
    @(posedge clk);
    #1;
    bus.valid = v;
    bus.in0 = a;
    bus.in1 = b;
    bus.tag = t;
    if (v) sbq.push_back(model(a, b, t, cyc));
  endtask

  task automatic chk_rst(string nm);
    chk({nm, "_valid_out"}, W'(bus.valid_out), '0);
    chk({nm, "_tag_out"}, W'(bus.tag_out), '0);
    chk({nm, "_borrow_out"}, W'(bus.borrow_out), '0);
    chk({nm, "_out"}, bus.out, '0);
    chk({nm, "_idle"}, W'(bus.idle), W'(1'b1));
`ifdef SUB_MOD_RANGE_CHK_EN
    chk({nm, "_range_err"}, W'(bus.range_err), '0);
`endif
  endtask

  // monitor: idle every cycle, results popped on valid_out
  always @(negedge clk) begin
    if (mon_en) begin
      chk("idle", W'(bus.idle), W'(sbq.size() == 0));
      if (bus.valid_out) begin
        if (sbq.size() == 0) begin
          chk("valid_out_unexpected", W'(bus.valid_out), '0);
        end else begin
          me = sbq.pop_front();
          chk("latency", W'(cyc - me.cyc), W'(LATENCY));
          chk("borrow_out", W'(bus.borrow_out), W'(me.bor));
          chk("tag_out", W'(bus.tag_out), W'(me.tag));
          if (me.dchk) chk("out", bus.out, me.out);
`ifdef SUB_MOD_RANGE_CHK_EN
          chk("range_err", W'(bus.range_err), W'(me.rerr));
`endif
        end
      end else if (sbq.size() > 0 && cyc >= sbq[0].cyc + LATENCY) begin
        me = sbq.pop_front();
        chk("valid_out_missing", W'(bus.valid_out), W'(1'b1));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a, b, one;
    logic v;
    one = W'(1);
    bus.valid = 1'b0;
    bus.in0 = '0;
    bus.in1 = '0;
    bus.tag = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_rst("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    drive(1'b1, W'(5), W'(3), 1'b1);
    drive(1'b0, '0, '0, 1'b0);
    drive(1'b1, W'(3), W'(5), 1'b0);
    drive(1'b1, '0, P - one, 1'b1);
    drive(1'b1, P - one, P - one, 1'b0);
    drive(1'b1, one << 27, one, 1'b1);
    drive(1'b1, one << 351, (one << 351) - one, 1'b0);
    a = rnd_fe();
    drive(1'b1, a, a, 1'b1);
`ifdef SUB_MOD_RANGE_CHK_EN
    drive(1'b1, P, '0, 1'b0);
    drive(1'b1, P - one, P - one, 1'b1);
    drive(1'b1, '0, P, 1'b0);
    drive(1'b1, '1, one, 1'b1);
`endif
    for (int i = 0; i < 14; i++) drive(1'b0, '0, '0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      pick(a, b);
      drive(1'b1, a, b, TAG_W'($urandom));
    end
    for (int i = 0; i < 1000; i++) begin
      pick(a, b);
      v = ($urandom_range(0, 3) != 0);
      drive(v, a, b, TAG_W'($urandom));
    end
    for (int i = 0; i < 14; i++) drive(1'b0, '0, '0, 1'b0);

    // four ops, then a fifth presented together with reset
    for (int i = 0; i < 4; i++) begin
      pick(a, b);
      drive(1'b1, a, b, TAG_W'($urandom));
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.valid = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk_rst("midrst");
    for (int i = 0; i < 12; i++) drive(1'b0, '0, '0, 1'b0);
    drive(1'b1, W'(7), W'(9), 1'b1);
    drive(1'b0, '0, '0, 1'b0);

    for (int i = 0; i < 40 && sbq.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    chk("drain", W'(sbq.size()), '0);
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
